crystal_scan_ctrl: RTL and testbench

Scan scheduler for the power-crystal wiring reader. It decides when a crystal-array scan runs and generates the `get_crystal_array` strobe that starts it. It waits out the probe sequence, then checks that the eight returned crystal-to-GPIO assignments form a legal permutation. A checked map is published to the ship logic; a failed check is retried a bounded number of times. It merges manual scan requests and a periodic auto-refresh into one request path, so the reader is never re-triggered mid-scan.

---
 rtl/crystal_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_crystal_scan_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crystal_scan_ctrl.sv
// Scan scheduler for the power-crystal wiring reader: strobes the reader, waits out
// the probe sequence, validates the returned crystal-to-GPIO permutation and retries.
module crystal_scan_ctrl #(
    parameter int          PULSE_CYCLES = 4,
    parameter logic [19:0] SCAN_WAIT    = 20'd450000,
    parameter logic [23:0] AUTO_PERIOD  = 24'd10000000,
    parameter int          MAX_RETRY    = 2
) (
    input  logic        system_clk,
    input  logic        rst,
    input  logic        scan_req,
    input  logic        auto_enable,
    input  logic [31:0] crystal_map_in,
    output logic        get_crystal_array,
    output logic [31:0] map_out,
    output logic        map_valid,
    output logic        map_error,
    output logic        busy,
    output logic        scan_done
);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_CHECK} state_t;

    localparam logic [19:0] PULSE_LAST = 20'(PULSE_CYCLES - 1);
    localparam logic [19:0] WAIT_LAST  = SCAN_WAIT - 20'd1;
    localparam logic [23:0] AUTO_LAST  = AUTO_PERIOD - 24'd1;
    localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic [23:0] auto_q, auto_d;
    logic        pending_q, pending_d;
    logic        req_q;
    logic [31:0] map_q, map_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic        strobe_q, busy_q;
    logic        req_rise, auto_fire, map_pass;

    // Legal map: every nibble addresses one of GPIOs 0..7 and together they cover all eight.
    function automatic logic map_ok(input logic [31:0] m);
        logic [7:0] seen;
        logic       in_range;
        seen     = '0;
        in_range = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (m[4*k+3]) in_range = 1'b0;
            else          seen[m[4*k +: 3]] = 1'b1;
        end
        return in_range && (seen == 8'hFF);
    endfunction

    always_comb begin
        req_rise  = scan_req & ~req_q;
        auto_fire = auto_enable && (auto_q == AUTO_LAST);
        auto_d    = auto_enable ? (auto_fire ? 24'd0 : auto_q + 24'd1) : 24'd0;
        map_pass  = map_ok(crystal_map_in);

        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        pending_d = pending_q;
        map_d     = map_q;
        valid_d   = valid_q;
        error_d   = error_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d   = S_PULSE;
                    cnt_d     = '0;
                    retry_d   = '0;
                    pending_d = 1'b0;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: begin
                if (map_pass) begin
                    map_d   = crystal_map_in;
                    valid_d = 1'b1;
                    error_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 8'd1;
                    cnt_d   = '0;
                    state_d = S_PULSE;
                end else begin
                    valid_d = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase

        // A new request in the launch cycle must survive the clear.
        if (req_rise || auto_fire) pending_d = 1'b1;
    end

    // Strobe and busy are registered from the next state so they align with the FSM.
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            auto_q    <= '0;
            pending_q <= 1'b0;
            req_q     <= 1'b0;
            map_q     <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            auto_q    <= auto_d;
            pending_q <= pending_d;
            req_q     <= scan_req;
            map_q     <= map_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            done_q    <= done_d;
            strobe_q  <= (state_d == S_PULSE);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign get_crystal_array = strobe_q;
    assign map_out           = map_q;
    assign map_valid         = valid_q;
    assign map_error         = error_q;
    assign busy              = busy_q;
    assign scan_done         = done_q;

endmodule

// File: tb/tb_crystal_scan_ctrl.sv
// Scoreboard bench for crystal_scan_ctrl: stimulus predicts each scan outcome from the
// permutation rule, a negedge monitor checks strobes and completed scans against it.
module tb_crystal_scan_ctrl;

    localparam int PC  = 2;
    localparam int SW  = 10;
    localparam int AP  = 50;
    localparam int MR  = 2;
    localparam int LAT = PC + SW + 1;

    logic        system_clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_req = 1'b0;
    logic        auto_enable = 1'b0;
    logic [31:0] crystal_map_in = '0;
    logic        get_crystal_array;
    logic [31:0] map_out;
    logic        map_valid, map_error, busy, scan_done;

    crystal_scan_ctrl #(
        .PULSE_CYCLES(PC),
        .SCAN_WAIT(20'(SW)),
        .AUTO_PERIOD(24'(AP)),
        .MAX_RETRY(MR)
    ) dut (
        .system_clk(system_clk),
        .rst(rst),
        .scan_req(scan_req),
        .auto_enable(auto_enable),
        .crystal_map_in(crystal_map_in),
        .get_crystal_array(get_crystal_array),
        .map_out(map_out),
        .map_valid(map_valid),
        .map_error(map_error),
        .busy(busy),
        .scan_done(scan_done)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [31:0] map;
        logic        vld;
        logic        err;
        int          strobes;
    } exp_t;

    exp_t        exp_q[$];
    int          rise_q[$];
    int          done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] last_good = '0;

    always @(posedge system_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A legal map is eight distinct values, all within 0..7.
    function automatic bit model_ok(input logic [31:0] m);
        int v[8];
        for (int k = 0; k < 8; k++) begin
            v[k] = int'(m[4*k +: 4]);
            if (v[k] > 7) return 1'b0;
        end
        for (int i = 0; i < 8; i++)
            for (int j = i + 1; j < 8; j++)
                if (v[i] == v[j]) return 1'b0;
        return 1'b1;
    endfunction

    // m0..m2 are the maps the reader presents at the first, second and third CHECK.
    task automatic expect_scan(input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m2);
        exp_t        e;
        logic [31:0] att[3];
        bit          found;
        att   = '{m0, m1, m2};
        found = 1'b0;
        e.strobes = MR + 1;
        for (int a = 0; a <= MR; a++) begin
            if (!found && model_ok(att[a])) begin
                found     = 1'b1;
                e.strobes = a + 1;
                last_good = att[a];
            end
        end
        e.map = last_good;
        e.vld = found;
        e.err = !found;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] rand_perm();
        int          a[8];
        int          j, t;
        logic [31:0] m;
        for (int i = 0; i < 8; i++) a[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = a[i]; a[i] = a[j]; a[j] = t;
        end
        for (int i = 0; i < 8; i++) m[4*i +: 4] = 4'(a[i]);
        return m;
    endfunction

    function automatic logic [31:0] rand_bad();
        logic [31:0] m;
        int          i, j;
        m = rand_perm();
        i = int'($urandom_range(7, 0));
        if ($urandom_range(1, 0) == 0) begin
            j = (i + 1 + int'($urandom_range(6, 0))) % 8;
            m[4*i +: 4] = m[4*j +: 4];
        end else begin
            m[4*i +: 4] = 4'(8 + $urandom_range(7, 0));
        end
        return m;
    endfunction

    // Monitor: strobe shape, busy consistency, and scoreboard pop on every scan_done.
    int   nstrobe = 0;
    int   slen = 0;
    int   first_rise = 0;
    logic prev_s = 1'b0;
    always @(negedge system_clk) begin
        exp_t e;
        if (rst) begin
            nstrobe = 0;
            slen    = 0;
            prev_s  = 1'b0;
        end else begin
            if (get_crystal_array) begin
                if (!prev_s) begin
                    nstrobe++;
                    rise_q.push_back(cyc);
                    if (nstrobe == 1) first_rise = cyc;
                    chk("busy_with_strobe", 32'(busy), 32'd1);
                end
                slen++;
            end else if (prev_s) begin
                chk("strobe_width", 32'(slen), 32'(PC));
                slen = 0;
            end
            prev_s = get_crystal_array;
            if (scan_done) begin
                done_cnt++;
                done_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_scan_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("map_out", map_out, e.map);
                    chk("map_valid", 32'(map_valid), 32'(e.vld));
                    chk("map_error", 32'(map_error), 32'(e.err));
                    chk("strobes_per_scan", 32'(nstrobe), 32'(e.strobes));
                    chk("scan_latency", 32'(cyc - first_rise), 32'(e.strobes * LAT));
                end
                nstrobe = 0;
            end
        end
    end

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic pulse_req();
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        tick();
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) chk({name, "_timeout"}, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_rises(input int target, input int budget, input string name);
        int n = 0;
        while (rise_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        if (rise_q.size() < target) chk({name, "_timeout"}, 32'(rise_q.size()), 32'(target));
    endtask

    initial begin
        int          r0, d0, e0;
        logic [31:0] m;

        // Reset state
        repeat (3) tick();
        chk("rst_strobe", 32'(get_crystal_array), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_map_out", map_out, 32'h0);
        chk("rst_valid", 32'(map_valid), 32'd0);
        chk("rst_error", 32'(map_error), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Clean scan
        crystal_map_in = 32'h76543210;
        expect_scan(crystal_map_in, crystal_map_in, crystal_map_in);
        pulse_req();
        wait_dones(1, 40, "clean");
        tick();

        // Duplicate map exhausts retries, previous map kept
        crystal_map_in = 32'h76543211;
        expect_scan(crystal_map_in, crystal_map_in, crystal_map_in);
        pulse_req();
        wait_dones(2, 80, "dup");
        tick();

        // Default nibble, corrected before the retry's CHECK
        crystal_map_in = 32'hF6543210;
        expect_scan(32'hF6543210, 32'h01234567, 32'h01234567);
        r0 = rise_q.size();
        pulse_req();
        wait_rises(r0 + 2, 60, "nibble_retry");
        crystal_map_in = 32'h01234567;
        wait_dones(3, 40, "nibble");
        tick();

        // Auto refresh
        crystal_map_in = rand_perm();
        repeat (3) expect_scan(crystal_map_in, crystal_map_in, crystal_map_in);
        r0 = rise_q.size();
        auto_enable = 1'b1;
        wait_dones(done_cnt + 3, 250, "auto");
        auto_enable = 1'b0;
        if (rise_q.size() >= r0 + 3) begin
            chk("auto_period_1", 32'(rise_q[r0+1] - rise_q[r0]), 32'(AP));
            chk("auto_period_2", 32'(rise_q[r0+2] - rise_q[r0+1]), 32'(AP));
        end
        repeat (120) tick();
        chk("auto_off_no_strobe", 32'(rise_q.size()), 32'(r0 + 3));
        expect_scan(crystal_map_in, crystal_map_in, crystal_map_in);
        e0 = cyc;
        d0 = done_cnt;
        auto_enable = 1'b1;
        wait_rises(r0 + 4, 80, "auto_restart");
        auto_enable = 1'b0;
        if (rise_q.size() >= r0 + 4)
            chk("auto_restart_delay", 32'((rise_q[r0+3] - e0) >= 46 && (rise_q[r0+3] - e0) <= 56), 32'd1);
        wait_dones(d0 + 1, 40, "auto_restart");
        tick();

        // Merged requests during WAIT
        crystal_map_in = rand_perm();
        expect_scan(crystal_map_in, crystal_map_in, crystal_map_in);
        expect_scan(crystal_map_in, crystal_map_in, crystal_map_in);
        r0 = rise_q.size();
        d0 = done_cnt;
        pulse_req();
        wait_rises(r0 + 1, 20, "merge_first");
        repeat (3) tick();
        repeat (3) pulse_req();
        wait_dones(d0 + 2, 80, "merge");
        if (rise_q.size() >= r0 + 2 && done_q.size() >= d0 + 1)
            chk("merge_restart_gap", 32'(rise_q[r0+1] - done_q[d0]), 32'd1);
        repeat (60) tick();
        chk("merge_single_followup", 32'(rise_q.size()), 32'(r0 + 2));

        // Reset mid-WAIT
        crystal_map_in = rand_perm();
        r0 = rise_q.size();
        d0 = done_cnt;
        pulse_req();
        wait_rises(r0 + 1, 20, "rst_wait_scan");
        repeat (4) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_wait_busy", 32'(busy), 32'd0);
        chk("rst_wait_strobe", 32'(get_crystal_array), 32'd0);
        chk("rst_wait_map_out", map_out, 32'h0);
        chk("rst_wait_valid", 32'(map_valid), 32'd0);
        last_good = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("rst_wait_no_done", 32'(done_cnt), 32'(d0));

        // Reset during PULSE drops the strobe asynchronously
        r0 = rise_q.size();
        pulse_req();
        wait_rises(r0 + 1, 20, "rst_pulse_scan");
        chk("pre_rst_strobe", 32'(get_crystal_array), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_pulse_strobe", 32'(get_crystal_array), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("rst_pulse_no_done", 32'(done_cnt), 32'(d0));

        // Randomized scans
        for (int n = 0; n < 10; n++) begin
            m = ($urandom_range(1, 0) == 0) ? rand_perm() : rand_bad();
            crystal_map_in = m;
            expect_scan(m, m, m);
            d0 = done_cnt;
            pulse_req();
            wait_dones(d0 + 1, 80, "random");
            repeat ($urandom_range(5, 0)) tick();
        end

        repeat (20) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
